// File: rtl/loader_pkg.sv
// Shared types and defaults for the program loader.
// Holds the FSM state encoding, default widths and the range-check helper.
// No logic of its own; imported by program_loader.
package loader_pkg;

  localparam int LOADER_DATA_WIDTH = 32;
  localparam int LOADER_MEM_ADDR_W = 10;
  localparam int LOADER_CNT_W      = 9;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPTURE,
    WRITE,
    FINISH
  } state_e;

  // True when a load of 'words' words starting at 'base' runs past the end of memory.
  function automatic logic exceeds_memory(input int base, input int words, input int addr_w);
    return (base + 4 * words) > (1 << addr_w);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Copies num_words instruction words from a source FIFO into instruction memory, holding the core meanwhile.
// Latency: 3 cycles per word (POP, CAPTURE, WRITE) plus one FINISH cycle, i.e. 3N+1 cycles from start to done.
// Backpressure: an empty FIFO stalls the POP state indefinitely; no pop is issued while fifo_empty is high.
module program_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = LOADER_DATA_WIDTH,
  parameter int MEM_ADDR_W = LOADER_MEM_ADDR_W,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LOADER_CNT_W-1:0] num_words,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  output logic [MEM_ADDR_W-1:0]   mem_wr_addr,
  output logic                    mem_w_en,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    cpu_hold
);

  state_e                  state_q, state_d;
  logic [LOADER_CNT_W-1:0] index_q, index_d;
  logic [LOADER_CNT_W-1:0] count_q, count_d;
  logic                    fifo_rd_en_q, fifo_rd_en_d;
  logic                    mem_w_en_q, mem_w_en_d;
  logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    booted_q, booted_d;
  logic                    cpu_hold_q, cpu_hold_d;

  // Next-state and registered-output computation; fifo_rd_en is decided one edge ahead from fifo_empty
  // so that the pop strobe itself is a flop output and only we ever drain the FIFO.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    count_d      = count_q;
    fifo_rd_en_d = 1'b0;
    mem_w_en_d   = 1'b0;
    mem_data_d   = mem_data_q;
    mem_addr_d   = mem_addr_q;
    done_d       = done_q;
    error_d      = error_q;
    booted_d     = booted_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          count_d = num_words;
          index_d = '0;
          if (num_words == '0) begin
            state_d = FINISH;
          end else if (exceeds_memory(BASE_ADDR, int'(num_words), MEM_ADDR_W)) begin
            error_d = 1'b1;
          end else begin
            state_d      = POP;
            fifo_rd_en_d = !fifo_empty;
          end
        end
      end
      POP: begin
        // The pop issued during this cycle delivers data in CAPTURE.
        if (fifo_rd_en_q) begin
          state_d = CAPTURE;
        end else begin
          fifo_rd_en_d = !fifo_empty;
        end
      end
      CAPTURE: begin
        mem_data_d = fifo_rd_data;
        mem_addr_d = MEM_ADDR_W'(BASE_ADDR + 4 * int'(index_q));
        mem_w_en_d = 1'b1;
        state_d    = WRITE;
      end
      WRITE: begin
        index_d = index_q + 1'b1;
        if ((index_q + 1'b1) == count_q) begin
          state_d = FINISH;
        end else begin
          state_d      = POP;
          fifo_rd_en_d = !fifo_empty;
        end
      end
      FINISH: begin
        done_d   = 1'b1;
        booted_d = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d != IDLE);
    cpu_hold_d = busy_d || !booted_d;
  end

  // State and output registers; reset parks the core in hold with nothing in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      index_q      <= '0;
      count_q      <= '0;
      fifo_rd_en_q <= 1'b0;
      mem_w_en_q   <= 1'b0;
      mem_data_q   <= '0;
      mem_addr_q   <= MEM_ADDR_W'(BASE_ADDR);
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      booted_q     <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      count_q      <= count_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_data_q   <= mem_data_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      booted_q     <= booted_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign fifo_rd_en   = fifo_rd_en_q;
  assign mem_w_en     = mem_w_en_q;
  assign mem_data_out = mem_data_q;
  assign mem_wr_addr  = mem_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign cpu_hold     = cpu_hold_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a FIFO model feeds the loader, a monitor logs every pop and write,
// and each load is compared against the expected word/address list taken straight from the FIFO contents.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Instance A: BASE_ADDR = 0
  logic        start;
  logic [8:0]  num_words;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = '0;
  logic [31:0] mem_data_out;
  logic [9:0]  mem_wr_addr;
  logic        mem_w_en, busy, done, error, cpu_hold;

  // Instance B: BASE_ADDR = 1020 (last word of memory)
  logic        start_hi;
  logic [8:0]  num_words_hi;
  logic        fifo_empty_hi = 1'b0;
  logic        fifo_rd_en_hi;
  logic [31:0] fifo_rd_data_hi = 32'hCAFE_0001;
  logic [31:0] mem_data_out_hi;
  logic [9:0]  mem_wr_addr_hi;
  logic        mem_w_en_hi, busy_hi, done_hi, error_hi, cpu_hold_hi;

  program_loader #(.DATA_WIDTH(32), .MEM_ADDR_W(10), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .mem_data_out(mem_data_out), .mem_wr_addr(mem_wr_addr), .mem_w_en(mem_w_en),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  program_loader #(.DATA_WIDTH(32), .MEM_ADDR_W(10), .BASE_ADDR(1020)) u_hi (
    .clk(clk), .rst(rst), .start(start_hi), .num_words(num_words_hi),
    .fifo_empty(fifo_empty_hi), .fifo_rd_en(fifo_rd_en_hi), .fifo_rd_data(fifo_rd_data_hi),
    .mem_data_out(mem_data_out_hi), .mem_wr_addr(mem_wr_addr_hi), .mem_w_en(mem_w_en_hi),
    .busy(busy_hi), .done(done_hi), .error(error_hi), .cpu_hold(cpu_hold_hi)
  );

  int total = 0;
  int bad   = 0;

  // FIFO model: written by the stimulus (wr_ptr), drained by the monitor (rd_ptr)
  logic [31:0] fifo_mem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int stall_cnt = 0;
  int stall_len_cfg = 0;
  int run_wr_base = 0;
  assign fifo_empty = (wr_ptr == rd_ptr) || (stall_cnt != 0);

  // Monitor logs
  logic [9:0]  wr_addr_log [1024];
  logic [31:0] wr_data_log [1024];
  int wr_n = 0, rd_n = 0, overlap_n = 0, underflow_n = 0, stall_pop_n = 0;
  int hi_wr_n = 0, hi_rd_n = 0, hi_busy_n = 0;
  logic [9:0]  hi_addr = '0;
  logic [31:0] hi_data = '0;

  always @(negedge clk) begin
    if (fifo_rd_en && stall_cnt != 0) stall_pop_n++;
    if (fifo_rd_en && mem_w_en) overlap_n++;
    if (fifo_rd_en) begin
      rd_n++;
      if (wr_ptr == rd_ptr) underflow_n++;
      else begin
        fifo_rd_data = fifo_mem[rd_ptr % 1024];
        rd_ptr++;
      end
    end
    if (mem_w_en) begin
      wr_addr_log[wr_n % 1024] = mem_wr_addr;
      wr_data_log[wr_n % 1024] = mem_data_out;
      wr_n++;
    end
    if (stall_cnt != 0) stall_cnt--;
    else if (mem_w_en && stall_len_cfg != 0 && (wr_n - run_wr_base) == 1) stall_cnt = stall_len_cfg;
  end

  always @(negedge clk) begin
    if (mem_w_en_hi) begin
      hi_wr_n++;
      hi_addr = mem_wr_addr_hi;
      hi_data = mem_data_out_hi;
    end
    if (fifo_rd_en_hi) hi_rd_n++;
    if (busy_hi) hi_busy_n++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr % 1024] = w;
    wr_ptr++;
  endtask

  // One complete load on instance A; expected writes are the next n FIFO words at 4-byte steps from 0.
  task automatic run_load(input int n, input int stall_len, input bit mid_start, input string tag);
    logic [31:0] exp_w [$];
    int base_wr, base_rd, cyc, budget, got;
    while ((wr_ptr - rd_ptr) < n) push($urandom);
    for (int i = 0; i < n; i++) exp_w.push_back(fifo_mem[(rd_ptr + i) % 1024]);
    base_wr = wr_n;
    base_rd = rd_n;
    run_wr_base = wr_n;
    stall_len_cfg = stall_len;
    budget = 3 * n + stall_len + 50;
    @(negedge clk);
    num_words = 9'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      if (cyc == 1 && n > 0) begin
        check({tag, "_busy"}, busy, 1);
        check({tag, "_hold"}, cpu_hold, 1);
      end
      start = mid_start && (cyc == 3);
      if (mid_start && cyc == 3) num_words = 9'(n + 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    #1;
    check({tag, "_done"}, done, 1);
    if (stall_len == 0) check({tag, "_latency"}, cyc, 3 * n + 1);
    got = wr_n - base_wr;
    check({tag, "_nwr"}, got, n);
    check({tag, "_nrd"}, rd_n - base_rd, n);
    for (int i = 0; i < n && i < got; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr_log[(base_wr + i) % 1024], 64'(4 * i));
      check($sformatf("%s_data%0d", tag, i), wr_data_log[(base_wr + i) % 1024], exp_w[i]);
    end
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_hold_end"}, cpu_hold, 0);
    check({tag, "_err_end"}, error, 0);
    stall_len_cfg = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base_wr, base_rd, cyc, hb;
    rst = 1'b1;
    start = 1'b0;
    num_words = '0;
    start_hi = 1'b0;
    num_words_hi = '0;

    // Reset state
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_w_en", mem_w_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_addr", mem_wr_addr, 0);
    check("rst_data", mem_data_out, 0);
    check("rst_addr_hi", mem_wr_addr_hi, 10'd1020);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("idle_hold", cpu_hold, 1);
    check("idle_nopop", rd_n, 0);
    check("idle_nowr", wr_n, 0);

    // Directed 3-word program
    push(32'h0000_0013);
    push(32'h0010_0093);
    push(32'h0020_8133);
    run_load(3, 0, 1'b0, "prog3");

    // Zero words
    run_load(0, 0, 1'b0, "zero");

    // FIFO runs dry for 5 cycles after word 1
    run_load(4, 5, 1'b0, "stall");
    check("stall_nopop", stall_pop_n, 0);

    // start pulsed mid-load is ignored
    run_load(5, 0, 1'b1, "mid");

    // Randomized loads
    for (int r = 0; r < 5; r++) begin
      int n, s;
      n = int'($urandom_range(1, 8));
      s = (r % 2 == 1) ? int'($urandom_range(1, 4)) : 0;
      run_load(n, s, 1'b0, $sformatf("rnd%0d", r));
    end

    // Out-of-range request on the high instance
    @(negedge clk);
    hb = hi_busy_n;
    num_words_hi = 9'd2;
    start_hi = 1'b1;
    @(negedge clk);
    start_hi = 1'b0;
    #1;
    check("hi_err", error_hi, 1);
    repeat (6) @(negedge clk);
    #1;
    check("hi_err_nowr", hi_wr_n, 0);
    check("hi_err_nopop", hi_rd_n, 0);
    check("hi_err_busy", hi_busy_n - hb, 0);
    check("hi_err_sticky", error_hi, 1);

    // Exactly-fitting request on the high instance: one word at 1020
    @(negedge clk);
    num_words_hi = 9'd1;
    start_hi = 1'b1;
    @(negedge clk);
    start_hi = 1'b0;
    cyc = 0;
    while (done_hi !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    check("hi_fit_done", done_hi, 1);
    check("hi_fit_latency", cyc, 4);
    check("hi_fit_err", error_hi, 0);
    check("hi_fit_nwr", hi_wr_n, 1);
    check("hi_fit_addr", hi_addr, 10'd1020);
    check("hi_fit_data", hi_data, 32'hCAFE_0001);

    // Reset during the write of word 2 of 4
    while ((wr_ptr - rd_ptr) < 4) push($urandom);
    base_wr = wr_n;
    @(negedge clk);
    num_words = 9'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(mem_w_en === 1'b1 && (wr_n - base_wr) == 2) && cyc < 60) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("mid_rst_reached", wr_n - base_wr, 2);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_w_en", mem_w_en, 0);
    check("mid_rst_rd_en", fifo_rd_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_hold", cpu_hold, 1);
    check("mid_rst_addr", mem_wr_addr, 0);
    check("mid_rst_data", mem_data_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    base_wr = wr_n;
    base_rd = rd_n;
    repeat (5) @(negedge clk);
    #1;
    check("post_rst_nowr", wr_n - base_wr, 0);
    check("post_rst_nopop", rd_n - base_rd, 0);
    check("post_rst_hold", cpu_hold, 1);
    run_load(1, 0, 1'b0, "after_rst");

    // Global invariants
    check("no_overlap", overlap_n, 0);
    check("no_underflow", underflow_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
